// File: rtl/spi_poll_pkg.sv
// Shared types and constants for the accelerometer burst-read poller.
// Holds the FSM state encoding, command/address bytes and the burst byte selector.
package spi_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        GUARD,
        WAITRDY,
        CAPTURE,
        DONE
    } poll_state_t;

    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam logic [7:0] CMD_WRITE  = 8'h0A;
    localparam logic [7:0] XDATA_L    = 8'h0E;
    localparam logic [7:0] TEMP_L     = 8'h14;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    localparam int BASE_BYTES = 8;
    localparam int TEMP_BYTES = 2;

    // Byte 0 is the command, byte 1 the start address, everything after clocks data out.
    function automatic logic [7:0] burst_byte(input logic [3:0] idx,
                                              input logic [7:0] cmd,
                                              input logic [7:0] addr);
        case (idx)
            4'd0:    return cmd;
            4'd1:    return addr;
            default: return DUMMY_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/poll_timer.sv
// Free-running interval counter producing a one-cycle tick every PERIOD cycles.
// Dropping enable parks the count at zero so re-enabling restarts a full period.
module poll_timer #(
    parameter int unsigned PERIOD = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/spi_accel_poller.sv
// Autonomous accelerometer burst-read sequencer driving the byte-level SPI master core.
// Define SPI_POLL_TEMP_EN to extend the burst with the temperature bytes and expose temp_data.
module spi_accel_poller
    import spi_poll_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 500000,
    parameter logic [7:0]  READ_CMD    = CMD_READ,
    parameter logic [7:0]  START_ADDR  = XDATA_L
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        enable,
    output logic [7:0]  spi_txdin,
    output logic        spi_txgo,
    input  logic        spi_txrdy,
    input  logic [7:0]  spi_rxdout,
    output logic        spi_frame,
    output logic [15:0] x_data,
    output logic [15:0] y_data,
    output logic [15:0] z_data,
`ifdef SPI_POLL_TEMP_EN
    output logic [15:0] temp_data,
`endif
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr
);

`ifdef SPI_POLL_TEMP_EN
    localparam int NBYTES = BASE_BYTES + TEMP_BYTES;
`else
    localparam int NBYTES = BASE_BYTES;
`endif
    localparam int NDATA = NBYTES - 2;
    localparam logic [3:0] LAST_INDEX = 4'(NBYTES - 1);

    poll_state_t state;
    poll_state_t state_next;

    logic       tick;
    logic       launch;
    logic       set_overrun;
    logic [3:0] index;
    logic [7:0] shadow [NDATA];

    poll_timer #(
        .PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        set_overrun = 1'b0;
        spi_txgo    = 1'b0;

        case (state)
            IDLE: begin
                if (tick) begin
                    if (spi_txrdy) begin
                        launch     = 1'b1;
                        state_next = SEND;
                    end else begin
                        set_overrun = 1'b1;
                    end
                end
            end
            SEND: begin
                spi_txgo   = 1'b1;
                state_next = GUARD;
            end
            GUARD: begin
                state_next = WAITRDY;
            end
            WAITRDY: begin
                if (spi_txrdy) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (index < LAST_INDEX) begin
                    state_next = SEND;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Ticks are never queued: any tick outside IDLE is simply reported.
        if (tick && (state != IDLE)) begin
            set_overrun = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            index        <= '0;
            spi_txdin    <= '0;
            spi_frame    <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            x_data       <= '0;
            y_data       <= '0;
            z_data       <= '0;
`ifdef SPI_POLL_TEMP_EN
            temp_data    <= '0;
`endif
            for (int i = 0; i < NDATA; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;

            if (launch) begin
                index     <= '0;
                spi_txdin <= burst_byte(4'd0, READ_CMD, START_ADDR);
                spi_frame <= 1'b1;
                busy      <= 1'b1;
            end

            if (state == CAPTURE) begin
                for (int i = 0; i < NDATA; i++) begin
                    if (index == 4'(i + 2)) begin
                        shadow[i] <= spi_rxdout;
                    end
                end
                index <= index + 4'd1;
                if (state_next == SEND) begin
                    spi_txdin <= burst_byte(index + 4'd1, READ_CMD, START_ADDR);
                end
            end

            // Outputs move only here, so an aborted burst never leaks partial samples.
            if (state == DONE) begin
                x_data       <= {shadow[1], shadow[0]};
                y_data       <= {shadow[3], shadow[2]};
                z_data       <= {shadow[5], shadow[4]};
`ifdef SPI_POLL_TEMP_EN
                temp_data    <= {shadow[7], shadow[6]};
`endif
                sample_valid <= 1'b1;
                spi_frame    <= 1'b0;
                busy         <= 1'b0;
            end

            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_accel_poller.sv
// Directed self-checking bench for spi_accel_poller with a behavioural SPI byte core.
// The core answers data byte n of each burst with base + n - 1.
module tb_spi_accel_poller;

`ifdef SPI_POLL_TEMP_EN
    localparam int NB = 10;
`else
    localparam int NB = 8;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic        enable;
    logic [7:0]  spi_txdin;
    logic        spi_txgo;
    logic        spi_txrdy;
    logic [7:0]  spi_rxdout;
    logic        spi_frame;
    logic [15:0] x_data;
    logic [15:0] y_data;
    logic [15:0] z_data;
`ifdef SPI_POLL_TEMP_EN
    logic [15:0] temp_data;
`endif
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic        overrun_clr;

    int compared   = 0;
    int mismatched = 0;

    logic       rdy_q;
    int         cnt;
    int         pos;
    logic [7:0] rxd;
    int         byte_time;
    logic [7:0] base;
    bit         hold;
    bit         force_busy;
    int         go_count    = 0;
    int         valid_count = 0;
    logic [7:0] tx_log [$];

    spi_accel_poller #(
        .POLL_PERIOD (64)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .enable       (enable),
        .spi_txdin    (spi_txdin),
        .spi_txgo     (spi_txgo),
        .spi_txrdy    (spi_txrdy),
        .spi_rxdout   (spi_rxdout),
        .spi_frame    (spi_frame),
        .x_data       (x_data),
        .y_data       (y_data),
        .z_data       (z_data),
`ifdef SPI_POLL_TEMP_EN
        .temp_data    (temp_data),
`endif
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    assign spi_txrdy  = rdy_q & ~force_busy;
    assign spi_rxdout = rxd;

    // Byte core model: busy for byte_time cycles after each go, unless stalled by hold.
    always @(posedge HCLK) begin
        if (!HRESETn) begin
            rdy_q <= 1'b1;
            cnt   <= 0;
            pos   <= 0;
            rxd   <= 8'h00;
        end else begin
            if (spi_txgo) begin
                rdy_q    <= 1'b0;
                cnt      <= byte_time;
                go_count <= go_count + 1;
                tx_log.push_back(spi_txdin);
            end else if (!rdy_q && !hold) begin
                if (cnt <= 1) begin
                    rdy_q <= 1'b1;
                    rxd   <= (pos >= 2) ? base + 8'(pos - 1) : 8'hEE;
                    pos   <= pos + 1;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (!spi_frame) begin
                pos <= 0;
            end
        end
    end

    always @(posedge HCLK) begin
        if (sample_valid) begin
            valid_count <= valid_count + 1;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_txgo(input string tag, input int limit, output int n);
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!spi_txgo && n < limit);
        check_output(tag, 64'(spi_txgo), 64'd1);
    endtask

    task automatic wait_valid(input string tag, input int limit, output int n);
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!sample_valid && n < limit);
        check_output(tag, 64'(sample_valid), 64'd1);
    endtask

    task automatic wait_go(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (go_count < target && n < limit) begin
            @(negedge HCLK);
            n++;
        end
        check_output(tag, 64'(go_count >= target), 64'd1);
    endtask

    task automatic wait_overrun(input string tag, input int limit, output int n);
        n = 0;
        while (!overrun && n < limit) begin
            @(negedge HCLK);
            n++;
        end
        check_output(tag, 64'(overrun), 64'd1);
    endtask

    initial begin
        int n;
        int g0;
        logic [7:0] exp_byte;

        HRESETn     = 1'b0;
        enable      = 1'b0;
        overrun_clr = 1'b0;
        byte_time   = 1;
        base        = 8'h00;
        hold        = 1'b0;
        force_busy  = 1'b0;
        repeat (3) @(negedge HCLK);

        check_output("rst_frame", 64'(spi_frame), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_txgo", 64'(spi_txgo), 64'd0);
        check_output("rst_txdin", 64'(spi_txdin), 64'h00);
        check_output("rst_x", 64'(x_data), 64'h0);
        check_output("rst_y", 64'(y_data), 64'h0);
        check_output("rst_z", 64'(z_data), 64'h0);
        check_output("rst_valid", 64'(sample_valid), 64'd0);
        check_output("rst_overrun", 64'(overrun), 64'd0);

        $display("[TB] enable held low");
        HRESETn = 1'b1;
        repeat (200) @(negedge HCLK);
        check_output("disabled_no_go", 64'(go_count), 64'd0);
        check_output("disabled_busy", 64'(busy), 64'd0);

        $display("[TB] nominal burst");
        tx_log.delete();
        enable = 1'b1;
        wait_txgo("first_go_seen", 100, n);
        check_output("first_tick_cycles", 64'(n), 64'd64);
        check_output("first_txdin", 64'(spi_txdin), 64'h0B);
        check_output("first_busy", 64'(busy), 64'd1);
        check_output("first_frame", 64'(spi_frame), 64'd1);
        wait_valid("nominal_valid_seen", 200, n);
        enable = 1'b0;
        check_output("nominal_latency", 64'(n), 64'(NB * 4 + 1));
        check_output("nominal_x", 64'(x_data), 64'h0201);
        check_output("nominal_y", 64'(y_data), 64'h0403);
        check_output("nominal_z", 64'(z_data), 64'h0605);
`ifdef SPI_POLL_TEMP_EN
        check_output("nominal_temp", 64'(temp_data), 64'h0807);
`endif
        check_output("nominal_busy_clear", 64'(busy), 64'd0);
        check_output("nominal_frame_clear", 64'(spi_frame), 64'd0);
        check_output("nominal_overrun", 64'(overrun), 64'd0);
        @(negedge HCLK);
        check_output("valid_one_cycle", 64'(sample_valid), 64'd0);
        check_output("valid_count", 64'(valid_count), 64'd1);
        check_output("txdin_count", 64'(tx_log.size()), 64'(NB));
        for (int i = 0; i < NB; i++) begin
            exp_byte = (i == 0) ? 8'h0B : (i == 1) ? 8'h0E : 8'h00;
            if (i < tx_log.size()) begin
                check_output($sformatf("txdin_seq%0d", i), 64'(tx_log[i]), 64'(exp_byte));
            end
        end

        $display("[TB] ready handshake stall");
        tx_log.delete();
        base   = 8'h10;
        g0     = go_count;
        enable = 1'b1;
        wait_go("stall_go3_seen", g0 + 3, 200);
        hold   = 1'b1;
        enable = 1'b0;
        repeat (100) @(negedge HCLK);
        check_output("stall_no_go", 64'(go_count), 64'(g0 + 3));
        check_output("stall_x_held", 64'(x_data), 64'h0201);
        check_output("stall_busy", 64'(busy), 64'd1);
        check_output("stall_frame", 64'(spi_frame), 64'd1);
        hold = 1'b0;
        wait_valid("stall_valid_seen", 200, n);
        check_output("stall_x", 64'(x_data), 64'h1211);
        check_output("stall_y", 64'(y_data), 64'h1413);
        check_output("stall_z", 64'(z_data), 64'h1615);
        check_output("stall_go_total", 64'(go_count), 64'(g0 + NB));

        $display("[TB] overrun from slow core");
        @(negedge HCLK);
        byte_time = 12;
        base      = 8'h20;
        g0        = go_count;
        enable    = 1'b1;
        wait_overrun("overrun_seen", 200, n);
        enable = 1'b0;
        check_output("overrun_cycle", 64'(n), 64'd128);
        check_output("overrun_while_busy", 64'(busy), 64'd1);
        wait_valid("overrun_valid_seen", 300, n);
        check_output("overrun_x", 64'(x_data), 64'h2221);
        check_output("overrun_y", 64'(y_data), 64'h2423);
        check_output("overrun_z", 64'(z_data), 64'h2625);
        repeat (20) @(negedge HCLK);
        check_output("overrun_no_second_burst", 64'(go_count), 64'(g0 + NB));
        check_output("overrun_sticky", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        @(negedge HCLK);
        overrun_clr = 1'b0;
        check_output("overrun_cleared", 64'(overrun), 64'd0);

        $display("[TB] clear and set together");
        byte_time   = 1;
        force_busy  = 1'b1;
        overrun_clr = 1'b1;
        g0          = go_count;
        enable      = 1'b1;
        wait_overrun("set_wins_seen", 100, n);
        check_output("set_wins_cycle", 64'(n), 64'd64);
        check_output("dropped_tick_busy", 64'(busy), 64'd0);
        check_output("dropped_tick_no_go", 64'(go_count), 64'(g0));
        enable = 1'b0;
        @(negedge HCLK);
        check_output("clear_after_set", 64'(overrun), 64'd0);
        overrun_clr = 1'b0;
        force_busy  = 1'b0;

        $display("[TB] reset mid-burst");
        @(negedge HCLK);
        base   = 8'h30;
        g0     = go_count;
        enable = 1'b1;
        wait_go("abort_go5_seen", g0 + 5, 200);
        check_output("abort_busy_before", 64'(busy), 64'd1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check_output("abort_frame", 64'(spi_frame), 64'd0);
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_txgo", 64'(spi_txgo), 64'd0);
        check_output("abort_x", 64'(x_data), 64'h0);
        check_output("abort_y", 64'(y_data), 64'h0);
        check_output("abort_z", 64'(z_data), 64'h0);
        HRESETn = 1'b1;
        tx_log.delete();
        wait_txgo("restart_go_seen", 100, n);
        check_output("restart_tick_cycles", 64'(n), 64'd64);
        check_output("restart_txdin", 64'(spi_txdin), 64'h0B);
        wait_valid("restart_valid_seen", 200, n);
        check_output("restart_x", 64'(x_data), 64'h3231);
        check_output("restart_y", 64'(y_data), 64'h3433);
        check_output("restart_z", 64'(z_data), 64'h3635);
        check_output("restart_txdin_count", 64'(tx_log.size()), 64'(NB));
        enable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_accel_poller.md
Name: spi_accel_poller

Overview:
- Autonomous sequencer for the byte-level SPI master core.
- Periodically issues an accelerometer burst read: command 0x0B, start address, then dummy bytes. Captures the returned X/Y/Z samples into holding registers and presents them with a valid strobe.
- Sits between the SPI core and the AHB peripheral wrapper, so software reads complete samples without byte-level polling.

Parameters:
- POLL_PERIOD, 500000: HCLK cycles between poll ticks (100 Hz at 50 MHz); minimum 64.
- READ_CMD, 8'h0B: accelerometer register-read command byte.
- START_ADDR, 8'h0E: first data register address (XDATA_L).

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  reset. Synchronous, active-low.
- enable  in  1  allows poll ticks; level-sensitive.
- spi_txdin  out  8  byte to SPI core.
- spi_txgo  out  1  one-cycle start strobe to SPI core.
- spi_txrdy  in  1  SPI core idle/ready for the next byte.
- spi_rxdout  in  8  byte received by SPI core during the last transfer.
- spi_frame  out  1  high for the whole burst; holds slave select across bytes.
- x_data  out  16  latest X sample, {high,low} bytes.
- y_data  out  16  latest Y sample.
- z_data  out  16  latest Z sample.
- sample_valid  out  1  one-cycle pulse when x/y/z update.
- busy  out  1  burst in progress.
- overrun  out  1  sticky: a tick arrived while busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (HRESETn=0 at a HCLK edge): every output is 0, FSM=IDLE, timer=0. Reset mid-burst aborts immediately; spi_frame drops the next cycle.
- Timer:
  - Counts 0..POLL_PERIOD-1 while enable=1 and wraps.
  - tick is generated at terminal count.
  - enable=0 holds the count at 0.
- FSM states: IDLE, SEND, GUARD, WAITRDY, CAPTURE, DONE.
- IDLE: on tick with spi_txrdy=1, go to SEND with byte index 0; set spi_frame=1 and busy=1. A tick with spi_txrdy=0 is dropped and sets overrun.
- SEND:
  - Drive spi_txdin by index: 0→READ_CMD, 1→START_ADDR, ≥2→8'h00.
  - Assert spi_txgo for exactly one cycle, then go to GUARD.
- GUARD: one cycle in which spi_txrdy is ignored, to cover core latency. Then go to WAITRDY.
- WAITRDY: wait for spi_txrdy=1. No timeout.
- CAPTURE:
  - For index ≥2, store spi_rxdout into shadow byte (index-2). Order: XL,XH,YL,YH,ZL,ZH.
  - Increment index. If index < NBYTES-1, return to SEND; else go to DONE.
- NBYTES is 8 (10 with the optional feature).
- DONE:
  - Copy all shadow bytes to the outputs simultaneously.
  - Pulse sample_valid for one cycle.
  - Clear spi_frame and busy, then return to IDLE.
- Latency: tick to sample_valid = NBYTES×(3 + core byte time) + 2 cycles.
- Outputs change only in DONE, so a partial burst never updates x/y/z.
- enable deasserted mid-burst: the burst completes normally; no new tick is generated.
- Tick while busy: set overrun and discard the tick. No queueing.
- overrun_clr and a new overrun in the same cycle: set wins.
- spi_txdin holds its value from SEND until the next SEND.

Optional Feature:
- Macro: SPI_POLL_TEMP_EN.
- Defined:
  - Burst extends by 2 bytes (TL,TH).
  - Adds output port temp_data (16 bits), updated in DONE with x/y/z.
  - NBYTES=10.
- Undefined:
  - No temp_data port.
  - NBYTES=8.
  - No temperature shadow registers.

Decomposition:
- Package spi_poll_pkg:
  - FSM state enum.
  - Command constants: CMD_READ 8'h0B, CMD_WRITE 8'h0A.
  - Register address constants: XDATA_L 8'h0E, TEMP_L 8'h14.
  - Base byte count 8 and temperature byte count 2.
  - Dummy byte 8'h00.
- Sub-module poll_timer: interval counter with enable, emitting a one-cycle tick.
- FSM and capture logic stay in spi_accel_poller.

Test Plan:
- Reset mid-burst: assert HRESETn=0 at byte 4 → next cycle spi_frame=0, busy=0, spi_txgo=0, x/y/z=0. After release, the first burst restarts at index 0 (txdin=0x0B).
- Nominal burst: POLL_PERIOD=64; a core model returns 0x01..0x06 → x_data=0x0201, y_data=0x0403, z_data=0x0605, one sample_valid pulse, and txdin sequence 0B,0E,00×6.
- Overrun: core byte time stretched so the burst exceeds 64 cycles → overrun=1 at the second tick and no second burst starts. overrun_clr pulse → overrun=0. Clear and set in the same cycle → overrun stays 1.
- enable low then high: enable=0 for 200 cycles → no spi_txgo. Re-enable → first tick exactly 64 cycles later.
- Ready handshake: hold spi_txrdy=0 for 100 cycles in WAITRDY → no further spi_txgo and outputs unchanged. Release → burst completes with correct data.
- SPI_POLL_TEMP_EN defined: 10 bytes sent; temp_data=0x0807 from returned bytes 07,08; x/y/z unchanged from the nominal case.
